// File: rtl/iosys_romload.sv
// iosys_romload: ROM-load streamer on the PicoRV32 memory bus.
// Firmware pushes 32-bit ROM words into a DEPTH-word FIFO. A two-state
// serialiser cuts each word into OUT_W-bit beats, low beat first, and
// hands them to the core's ROM loader over a valid/ready handshake.
// Optional feature macro: IOSYS_ROMLOAD_CSUM_EN adds a 16-bit running
// byte checksum readable at BASE_ADDR+0xC.
module iosys_romload #(
   parameter logic [31:0] BASE_ADDR = 32'h0200_0030,
   parameter int          DEPTH     = 8,
   parameter int          OUT_W     = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             mem_valid,
   input  logic [31:0]      mem_addr,
   input  logic [31:0]      mem_wdata,
   input  logic [3:0]       mem_wstrb,
   output logic             mem_ready,
   output logic [31:0]      mem_rdata,
   output logic             rom_loading,
   output logic [OUT_W-1:0] rom_do,
   output logic             rom_do_valid,
   input  logic             rom_do_ready
);

   localparam int          AW         = $clog2(DEPTH);
   localparam int          NBEATS     = 32 / OUT_W;
   localparam logic [1:0]  LAST_BEAT  = 2'(NBEATS - 1);
   localparam logic [31:0] COUNT_STEP = 32'(OUT_W / 8);

   generate
      if (OUT_W != 8 && OUT_W != 16) begin : g_bad_out_w
         $error("iosys_romload: OUT_W must be 8 or 16");
      end
      if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
         $error("iosys_romload: DEPTH must be a power of two and at least 2");
      end
   endgenerate

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } serState_e;

   serState_e   state_q, state_d;
   logic [31:0] word_q, word_d;
   logic [1:0]  beat_q, beat_d;
   logic        loading_q, loading_d;
   logic        stopPending_q, stopPending_d;
   logic [31:0] count_q, count_d;
   logic [AW:0] wrPtr_q, rdPtr_q;
   logic [31:0] fifoMem [DEPTH];

   logic selCtrl, selData, selCount, selCsum;
   logic isWrite, ctrlWrite, startCmd, stopCmd;
   logic fifoEmpty, fifoFull, push, pop, xfer;

   assign selCtrl  = mem_valid && (mem_addr == BASE_ADDR);
   assign selData  = mem_valid && (mem_addr == BASE_ADDR + 32'd4);
   assign selCount = mem_valid && (mem_addr == BASE_ADDR + 32'd8);
   assign selCsum  = mem_valid && (mem_addr == BASE_ADDR + 32'd12);
   assign isWrite  = |mem_wstrb;

   assign ctrlWrite = selCtrl && isWrite;
   assign startCmd  = ctrlWrite && (mem_wdata[7:0] == 8'd1) && !loading_q;
   assign stopCmd   = ctrlWrite && (mem_wdata[7:0] == 8'd0) && loading_q;

   // The extra pointer bit tells full from empty when the indices match.
   assign fifoEmpty = (wrPtr_q == rdPtr_q);
   assign fifoFull  = (wrPtr_q[AW] != rdPtr_q[AW]) &&
                      (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);

   // Full is judged on registered state, so a same-cycle pop never frees
   // the slot for a push in that cycle.
   assign push = selData && isWrite && loading_q && !fifoFull;

   assign rom_do_valid = (state_q == ST_SHIFT);
   assign rom_do       = rom_do_valid ? word_q[OUT_W-1:0] : '0;
   assign xfer         = rom_do_valid && rom_do_ready;
   assign rom_loading  = loading_q;

   // Bus handshake: only a DATA write into a full FIFO while loading
   // stalls the CPU; every other selected access completes at once.
   always_comb begin
      mem_ready = 1'b0;
      if (selCtrl || selCount || selCsum) begin
         mem_ready = 1'b1;
      end
      if (selData) begin
         mem_ready = !(isWrite && loading_q && fifoFull);
      end
   end

   // Read mux; unselected or write-only registers return zero.
   always_comb begin
      mem_rdata = '0;
      if (selCtrl) begin
         mem_rdata = {28'b0, stopPending_q, fifoEmpty, fifoFull, loading_q};
      end else if (selCount) begin
         mem_rdata = count_q;
      end else if (selCsum) begin
`ifdef IOSYS_ROMLOAD_CSUM_EN
         mem_rdata = {16'b0, csum_q};
`else
         mem_rdata = '0;
`endif
      end
   end

   // FIFO storage needs no reset: clearing the pointers drops its contents.
   always_ff @(posedge clk) begin
      if (push) begin
         fifoMem[wrPtr_q[AW-1:0]] <= mem_wdata;
      end
   end

   // FIFO pointers advance on accepted pushes and serialiser pops.
   always_ff @(posedge clk) begin
      if (reset) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
      end else begin
         if (push) begin
            wrPtr_q <= wrPtr_q + 1'b1;
         end
         if (pop) begin
            rdPtr_q <= rdPtr_q + 1'b1;
         end
      end
   end

   // Serialiser next state: load a word when idle, shift one beat per
   // transfer, and chain straight into the next word after the last beat.
   always_comb begin
      state_d = state_q;
      word_d  = word_q;
      beat_d  = beat_q;
      pop     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!fifoEmpty) begin
               pop     = 1'b1;
               word_d  = fifoMem[rdPtr_q[AW-1:0]];
               beat_d  = '0;
               state_d = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (rom_do_ready) begin
               if (beat_q == LAST_BEAT) begin
                  if (!fifoEmpty) begin
                     pop    = 1'b1;
                     word_d = fifoMem[rdPtr_q[AW-1:0]];
                     beat_d = '0;
                  end else begin
                     state_d = ST_IDLE;
                  end
               end else begin
                  word_d = word_q >> OUT_W;
                  beat_d = beat_q + 2'd1;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Session control and byte counter; session end outranks a late stop.
   always_comb begin
      loading_d     = loading_q;
      stopPending_d = stopPending_q;
      count_d       = count_q;
      if (xfer) begin
         count_d = count_q + COUNT_STEP;
      end
      if (startCmd) begin
         loading_d = 1'b1;
         count_d   = '0;
      end else if (stopCmd) begin
         stopPending_d = 1'b1;
      end
      if (stopPending_q && fifoEmpty && (state_q == ST_IDLE)) begin
         loading_d     = 1'b0;
         stopPending_d = 1'b0;
      end
   end

   // State registers for the serialiser, session flags and counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         word_q        <= '0;
         beat_q        <= '0;
         loading_q     <= 1'b0;
         stopPending_q <= 1'b0;
         count_q       <= '0;
      end else begin
         state_q       <= state_d;
         word_q        <= word_d;
         beat_q        <= beat_d;
         loading_q     <= loading_d;
         stopPending_q <= stopPending_d;
         count_q       <= count_d;
      end
   end

`ifdef IOSYS_ROMLOAD_CSUM_EN
   logic [15:0] csum_q, csum_d, beatSum;

   // Sum of the bytes in the beat currently on rom_do.
   always_comb begin
      beatSum = '0;
      for (int b = 0; b < OUT_W / 8; b++) begin
         beatSum = beatSum + 16'(rom_do[8*b +: 8]);
      end
   end

   // Checksum accumulates every transferred byte and restarts per session.
   always_comb begin
      csum_d = csum_q;
      if (xfer) begin
         csum_d = csum_q + beatSum;
      end
      if (startCmd) begin
         csum_d = '0;
      end
   end

   // Checksum register.
   always_ff @(posedge clk) begin
      if (reset) begin
         csum_q <= '0;
      end else begin
         csum_q <= csum_d;
      end
   end
`endif

endmodule

// File: tb/tb_iosys_romload.sv
// Directed bench for iosys_romload: an 8-bit-beat instance carries most
// scenarios, a 16-bit-beat instance on the same bus covers wide beats.
module tb_iosys_romload;

   localparam logic [31:0] BASE    = 32'h0200_0030;
   localparam logic [31:0] A_CTRL  = BASE;
   localparam logic [31:0] A_DATA  = BASE + 32'd4;
   localparam logic [31:0] A_COUNT = BASE + 32'd8;
   localparam logic [31:0] A_CSUM  = BASE + 32'd12;
   localparam int          DEPTH   = 8;

   logic        clk = 1'b0;
   logic        reset;
   logic        memValid;
   logic [31:0] memAddr;
   logic [31:0] memWdata;
   logic [3:0]  memWstrb;
   logic        romDoReady;

   logic        memReady, romLoading, romDoValid;
   logic [31:0] memRdata;
   logic [7:0]  romDo;
   logic        memReady16, romLoading16, romDoValid16;
   logic [31:0] memRdata16;
   logic [15:0] romDo16;

   int testsRun    = 0;
   int testsFailed = 0;

   always #5 clk = ~clk;

   iosys_romload #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .OUT_W(8)) dut (
      .clk(clk), .reset(reset), .mem_valid(memValid), .mem_addr(memAddr),
      .mem_wdata(memWdata), .mem_wstrb(memWstrb), .mem_ready(memReady),
      .mem_rdata(memRdata), .rom_loading(romLoading), .rom_do(romDo),
      .rom_do_valid(romDoValid), .rom_do_ready(romDoReady)
   );

   iosys_romload #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .OUT_W(16)) dut16 (
      .clk(clk), .reset(reset), .mem_valid(memValid), .mem_addr(memAddr),
      .mem_wdata(memWdata), .mem_wstrb(memWstrb), .mem_ready(memReady16),
      .mem_rdata(memRdata16), .rom_loading(romLoading16), .rom_do(romDo16),
      .rom_do_valid(romDoValid16), .rom_do_ready(romDoReady)
   );

   // Word k carries bytes 4k+1 .. 4k+4, lowest byte first on the wire.
   function automatic logic [31:0] wordOf(input int k);
      return {8'(4*k+4), 8'(4*k+3), 8'(4*k+2), 8'(4*k+1)};
   endfunction

   task automatic doReset();
      reset = 1'b1; memValid = 1'b0; memAddr = '0; memWdata = '0;
      memWstrb = '0; romDoReady = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   // Holds a write on the bus until the 8-bit instance signals ready.
   task automatic busWrite(input logic [31:0] addr, input logic [31:0] data,
                           input int budget, output bit ok);
      memValid = 1'b1; memAddr = addr; memWdata = data; memWstrb = 4'hF;
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         #1;
         if (memReady === 1'b1) begin ok = 1'b1; break; end
         @(posedge clk);
      end
      @(posedge clk);
      #1 memValid = 1'b0; memWstrb = 4'h0;
   endtask

   task automatic busRead(input logic [31:0] addr, input bit wide,
                          output logic [31:0] data, output logic rdy);
      memValid = 1'b1; memAddr = addr; memWstrb = 4'h0;
      #1;
      data = wide ? memRdata16 : memRdata;
      rdy  = wide ? memReady16 : memReady;
      @(posedge clk);
      #1 memValid = 1'b0;
   endtask

   task automatic test_reset();
      logic [31:0] rd; logic rdy;
      doReset();
      testsRun++; if (romLoading !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_loading: got %b expected 0", romLoading); end
      testsRun++; if (romDoValid !== 1'b0 || romDo !== 8'h00) begin testsFailed++; $display("[TB] FAIL reset_do: got valid=%b do=%h expected 0/00", romDoValid, romDo); end
      busRead(A_CTRL, 1'b0, rd, rdy);
      testsRun++; if (rd !== 32'h4 || rdy !== 1'b1) begin testsFailed++; $display("[TB] FAIL reset_ctrl: got %h rdy=%b expected 00000004 rdy=1", rd, rdy); end
      busRead(A_COUNT, 1'b0, rd, rdy);
      testsRun++; if (rd !== 32'h0) begin testsFailed++; $display("[TB] FAIL reset_count: got %h expected 0", rd); end
   endtask

   task automatic test_idle_bus();
      logic [31:0] rd; logic rdy; bit ok;
      doReset();
      busWrite(A_DATA, 32'hDEAD_BEEF, 4, ok);
      testsRun++; if (ok !== 1'b1) begin testsFailed++; $display("[TB] FAIL idle_data_ready: got %b expected 1", ok); end
      repeat (2) @(posedge clk);
      #1;
      testsRun++; if (romDoValid !== 1'b0) begin testsFailed++; $display("[TB] FAIL idle_discard: got valid=%b expected 0", romDoValid); end
      busRead(A_DATA, 1'b0, rd, rdy);
      testsRun++; if (rd !== 32'h0 || rdy !== 1'b1) begin testsFailed++; $display("[TB] FAIL data_read: got %h rdy=%b expected 0 rdy=1", rd, rdy); end
      memValid = 1'b1; memAddr = BASE + 32'h10; memWstrb = 4'h0;
      #1;
      testsRun++; if (memReady !== 1'b0 || memRdata !== 32'h0) begin testsFailed++; $display("[TB] FAIL unselected: got rdy=%b rdata=%h expected 0/0", memReady, memRdata); end
      @(posedge clk);
      #1 memValid = 1'b0;
   endtask

   task automatic test_stream_bytes();
      logic [31:0] rd; logic rdy; bit ok; logic [7:0] expB;
      doReset();
      busWrite(A_CTRL, 32'h1, 4, ok);
      romDoReady = 1'b1;
      busWrite(A_DATA, 32'h4433_2211, 4, ok);
      testsRun++; if (romDoValid !== 1'b0) begin testsFailed++; $display("[TB] FAIL stream_latency: got valid=%b expected 0", romDoValid); end
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1;
         expB = 8'(8'h11 * (i + 1));
         testsRun++; if (romDoValid !== 1'b1 || romDo !== expB) begin testsFailed++; $display("[TB] FAIL stream_beat%0d: got valid=%b do=%h expected 1/%h", i, romDoValid, romDo, expB); end
      end
      @(posedge clk);
      #1;
      testsRun++; if (romDoValid !== 1'b0) begin testsFailed++; $display("[TB] FAIL stream_end: got valid=%b expected 0", romDoValid); end
      busRead(A_COUNT, 1'b0, rd, rdy);
      testsRun++; if (rd !== 32'd4) begin testsFailed++; $display("[TB] FAIL stream_count: got %0d expected 4", rd); end
   endtask

   task automatic test_wide();
      bit ok;
      doReset();
      busWrite(A_CTRL, 32'h1, 4, ok);
      romDoReady = 1'b1;
      busWrite(A_DATA, 32'hBEEF_CAFE, 4, ok);
      testsRun++; if (romLoading16 !== 1'b1 || romDoValid16 !== 1'b0) begin testsFailed++; $display("[TB] FAIL wide_start: got loading=%b valid=%b expected 1/0", romLoading16, romDoValid16); end
      @(posedge clk);
      #1;
      testsRun++; if (romDoValid16 !== 1'b1 || romDo16 !== 16'hCAFE) begin testsFailed++; $display("[TB] FAIL wide_beat0: got valid=%b do=%h expected 1/cafe", romDoValid16, romDo16); end
      @(posedge clk);
      #1;
      testsRun++; if (romDoValid16 !== 1'b1 || romDo16 !== 16'hBEEF) begin testsFailed++; $display("[TB] FAIL wide_beat1: got valid=%b do=%h expected 1/beef", romDoValid16, romDo16); end
      @(posedge clk);
      #1;
      testsRun++; if (romDoValid16 !== 1'b0) begin testsFailed++; $display("[TB] FAIL wide_end: got valid=%b expected 0", romDoValid16); end
   endtask

   task automatic test_backpressure();
      logic [31:0] rd; logic rdy; bit ok, allOk, stallOk;
      doReset();
      busWrite(A_CTRL, 32'h1, 4, ok);
      romDoReady = 1'b0;
      // One word moves into the serialiser, so DEPTH+1 writes fit.
      allOk = 1'b1;
      for (int k = 0; k <= DEPTH; k++) begin
         busWrite(A_DATA, wordOf(k), 4, ok);
         if (!ok) allOk = 1'b0;
      end
      testsRun++; if (allOk !== 1'b1) begin testsFailed++; $display("[TB] FAIL bp_fill: got accepted=%b expected 1", allOk); end
      busRead(A_CTRL, 1'b0, rd, rdy);
      testsRun++; if (rd !== 32'h3) begin testsFailed++; $display("[TB] FAIL bp_ctrl_full: got %h expected 00000003", rd); end
      memValid = 1'b1; memAddr = A_DATA; memWdata = wordOf(DEPTH + 1); memWstrb = 4'hF;
      stallOk = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         if (memReady !== 1'b0 || romDoValid !== 1'b1 || romDo !== 8'h01) stallOk = 1'b0;
         @(posedge clk);
      end
      testsRun++; if (stallOk !== 1'b1) begin testsFailed++; $display("[TB] FAIL bp_stall: got rdy=%b valid=%b do=%h expected 0/1/01", memReady, romDoValid, romDo); end
      #1 romDoReady = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 12; i++) begin
         #1;
         if (memReady === 1'b1) begin ok = 1'b1; break; end
         @(posedge clk);
      end
      @(posedge clk);
      #1 memValid = 1'b0; memWstrb = 4'h0;
      testsRun++; if (ok !== 1'b1) begin testsFailed++; $display("[TB] FAIL bp_release: got ready=%b expected 1 within 12 cycles", ok); end
      repeat (50) @(posedge clk);
      #1;
      busRead(A_COUNT, 1'b0, rd, rdy);
      testsRun++; if (rd !== 32'(4 * (DEPTH + 2))) begin testsFailed++; $display("[TB] FAIL bp_count: got %0d expected %0d", rd, 4 * (DEPTH + 2)); end
      busRead(A_CTRL, 1'b0, rd, rdy);
      testsRun++; if (rd !== 32'h5) begin testsFailed++; $display("[TB] FAIL bp_ctrl_drained: got %h expected 00000005", rd); end
   endtask

   task automatic test_stop();
      logic [31:0] rd; logic rdy; bit ok, xfer, seqOk, earlyDrop; int nBytes;
      doReset();
      busWrite(A_CTRL, 32'h1, 4, ok);
      romDoReady = 1'b0;
      for (int k = 0; k < 3; k++) busWrite(A_DATA, wordOf(k), 4, ok);
      busWrite(A_CTRL, 32'h0, 4, ok);
      busRead(A_CTRL, 1'b0, rd, rdy);
      testsRun++; if (rd !== 32'h9) begin testsFailed++; $display("[TB] FAIL stop_pending: got %h expected 00000009", rd); end
      nBytes = 0; seqOk = 1'b1; earlyDrop = 1'b0;
      for (int c = 0; c < 200 && nBytes < 12; c++) begin
         romDoReady = ((c % 2) == 0);
         #1;
         xfer = romDoValid && romDoReady;
         if (romLoading !== 1'b1) earlyDrop = 1'b1;
         if (xfer && romDo !== 8'(nBytes + 1)) seqOk = 1'b0;
         @(posedge clk);
         #1;
         if (xfer) nBytes++;
      end
      testsRun++; if (nBytes !== 12 || seqOk !== 1'b1) begin testsFailed++; $display("[TB] FAIL stop_stream: got bytes=%0d order=%b expected 12/1", nBytes, seqOk); end
      testsRun++; if (earlyDrop !== 1'b0 || romLoading !== 1'b1) begin testsFailed++; $display("[TB] FAIL stop_hold: got early=%b loading=%b expected 0/1", earlyDrop, romLoading); end
      @(posedge clk);
      #1;
      testsRun++; if (romLoading !== 1'b0) begin testsFailed++; $display("[TB] FAIL stop_fall: got loading=%b expected 0", romLoading); end
      busRead(A_CTRL, 1'b0, rd, rdy);
      testsRun++; if (rd !== 32'h4) begin testsFailed++; $display("[TB] FAIL stop_ctrl: got %h expected 00000004", rd); end
   endtask

   task automatic test_reset_mid();
      logic [31:0] rd; logic rdy; bit ok;
      doReset();
      busWrite(A_CTRL, 32'h1, 4, ok);
      romDoReady = 1'b0;
      for (int k = 0; k < 3; k++) busWrite(A_DATA, wordOf(k), 4, ok);
      romDoReady = 1'b1;
      repeat (2) @(posedge clk);
      #1 romDoReady = 1'b0;
      busRead(A_COUNT, 1'b0, rd, rdy);
      testsRun++; if (rd !== 32'd2) begin testsFailed++; $display("[TB] FAIL mid_count_pre: got %0d expected 2", rd); end
      reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      testsRun++; if (romDoValid !== 1'b0 || romDo !== 8'h00 || romLoading !== 1'b0) begin testsFailed++; $display("[TB] FAIL mid_outputs: got valid=%b do=%h loading=%b expected 0/00/0", romDoValid, romDo, romLoading); end
      busRead(A_CTRL, 1'b0, rd, rdy);
      testsRun++; if (rd !== 32'h4) begin testsFailed++; $display("[TB] FAIL mid_ctrl: got %h expected 00000004", rd); end
      busRead(A_COUNT, 1'b0, rd, rdy);
      testsRun++; if (rd !== 32'h0) begin testsFailed++; $display("[TB] FAIL mid_count: got %h expected 0", rd); end
   endtask

   task automatic test_csum();
      logic [31:0] rd, expC; logic rdy; bit ok;
`ifdef IOSYS_ROMLOAD_CSUM_EN
      expC = 32'h0000_03FC;
`else
      expC = 32'h0;
`endif
      doReset();
      busWrite(A_CTRL, 32'h1, 4, ok);
      romDoReady = 1'b1;
      busWrite(A_DATA, 32'hFFFF_FFFF, 4, ok);
      repeat (8) @(posedge clk);
      #1;
      busRead(A_CSUM, 1'b0, rd, rdy);
      testsRun++; if (rd !== expC || rdy !== 1'b1) begin testsFailed++; $display("[TB] FAIL csum: got %h rdy=%b expected %h rdy=1", rd, rdy, expC); end
   endtask

   initial begin
      test_reset();
      test_idle_bus();
      test_stream_bytes();
      test_wide();
      test_backpressure();
      test_stop();
      test_reset_mid();
      test_csum();
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
